// File: rtl/blob_centroid.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : blob_centroid
// Purpose  : Accumulates the lit-pixel count and the column/row sums of a
//            thresholded video frame.  On the last pixel it snapshots the
//            totals and runs two parallel restoring dividers (one quotient bit
//            per cycle).  It then publishes the blob centroid with a one-cycle
//            find_corners_flag pulse.  Accumulation never stops, so the next
//            frame can stream in while the current frame is still dividing.
// Ports    : clk_in            - system clock
//            rst_in            - synchronous active-high reset
//            pixel_valid_in    - pixel/hcount/vcount qualifier
//            hcount_in         - pixel column
//            vcount_in         - pixel row
//            pixel_data_in     - thresholded pixel, 1 = lit
//            x_center          - centroid column of last valid frame
//            y_center          - centroid row of last valid frame
//            find_corners_flag - one-cycle "new centroid" pulse
//            busy_out          - high while dividing or publishing
// Revision : 1.0 - initial release
// ============================================================================
module blob_centroid #(
    parameter int WIDTH      = 240,
    parameter int HEIGHT     = 320,
    parameter int MIN_PIXELS = 64
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      pixel_valid_in,
    input  logic [$clog2(WIDTH)-1:0]  hcount_in,
    input  logic [$clog2(HEIGHT)-1:0] vcount_in,
    input  logic                      pixel_data_in,
    output logic [$clog2(WIDTH)-1:0]  x_center,
    output logic [$clog2(HEIGHT)-1:0] y_center,
    output logic                      find_corners_flag,
    output logic                      busy_out
);

    localparam int c_HW      = $clog2(WIDTH);
    localparam int c_VW      = $clog2(HEIGHT);
    localparam int c_CNT_W   = $clog2(WIDTH * HEIGHT + 1);
    localparam int c_SUM_W   = 25;
    localparam int c_ITER_W  = $clog2(c_SUM_W);

    localparam logic [c_HW-1:0]     c_H_LAST    = c_HW'(WIDTH - 1);
    localparam logic [c_VW-1:0]     c_V_LAST    = c_VW'(HEIGHT - 1);
    localparam logic [c_SUM_W-1:0]  c_X_MAX     = c_SUM_W'(WIDTH - 1);
    localparam logic [c_SUM_W-1:0]  c_Y_MAX     = c_SUM_W'(HEIGHT - 1);
    localparam logic [c_ITER_W-1:0] c_LAST_ITER = c_ITER_W'(c_SUM_W - 1);

    typedef enum logic [1:0] {
        c_ACCUM  = 2'd0,
        c_DIVIDE = 2'd1,
        c_OUTPUT = 2'd2
    } state_t;

    state_t               r_state;

    // Running totals of the frame currently streaming in
    logic [c_CNT_W-1:0]   r_count;
    logic [c_SUM_W-1:0]   r_sum_x;
    logic [c_SUM_W-1:0]   r_sum_y;

    // Divider registers: quotient registers start out holding the dividend
    // and have quotient bits shifted in at the bottom as dividend bits leave
    // at the top.
    logic [c_CNT_W-1:0]   r_divisor;
    logic [c_SUM_W-1:0]   r_quo_x;
    logic [c_SUM_W-1:0]   r_quo_y;
    logic [c_CNT_W-1:0]   r_rem_x;
    logic [c_CNT_W-1:0]   r_rem_y;
    logic [c_ITER_W-1:0]  r_iter;

    logic                 w_accept;
    logic                 w_lit;
    logic                 w_last;
    logic                 w_enough;
    logic [c_CNT_W-1:0]   w_count_add;
    logic [c_SUM_W-1:0]   w_sum_x_add;
    logic [c_SUM_W-1:0]   w_sum_y_add;

    logic [c_CNT_W:0]     w_rem_x_sh;
    logic [c_CNT_W:0]     w_rem_y_sh;
    logic                 w_ge_x;
    logic                 w_ge_y;
    logic [c_CNT_W-1:0]   w_rem_x_nx;
    logic [c_CNT_W-1:0]   w_rem_y_nx;
    logic [c_HW-1:0]      w_x_clamp;
    logic [c_VW-1:0]      w_y_clamp;

    // ------------------------------------------------------------------
    // Pixel qualification and accumulation (comparisons done at 32 bits
    // so a power-of-two frame size still compares correctly)
    // ------------------------------------------------------------------
    assign w_accept = pixel_valid_in
                      && (32'(hcount_in) < WIDTH)
                      && (32'(vcount_in) < HEIGHT);
    assign w_lit    = w_accept && pixel_data_in;
    assign w_last   = w_accept && (hcount_in == c_H_LAST) && (vcount_in == c_V_LAST);

    // Totals including the pixel on this cycle; the snapshot uses these so
    // the last pixel is counted in its own frame.
    assign w_count_add = r_count + c_CNT_W'(w_lit);
    assign w_sum_x_add = r_sum_x + (w_lit ? c_SUM_W'(hcount_in) : '0);
    assign w_sum_y_add = r_sum_y + (w_lit ? c_SUM_W'(vcount_in) : '0);
    assign w_enough    = (32'(w_count_add) >= MIN_PIXELS);

    // ------------------------------------------------------------------
    // One restoring-division step per divider.  The remainder is always
    // below the divisor, so the subtraction can be done at divisor width.
    // ------------------------------------------------------------------
    assign w_rem_x_sh = {r_rem_x, r_quo_x[c_SUM_W-1]};
    assign w_rem_y_sh = {r_rem_y, r_quo_y[c_SUM_W-1]};
    assign w_ge_x     = (w_rem_x_sh >= {1'b0, r_divisor});
    assign w_ge_y     = (w_rem_y_sh >= {1'b0, r_divisor});
    assign w_rem_x_nx = w_ge_x ? (w_rem_x_sh[c_CNT_W-1:0] - r_divisor)
                               : w_rem_x_sh[c_CNT_W-1:0];
    assign w_rem_y_nx = w_ge_y ? (w_rem_y_sh[c_CNT_W-1:0] - r_divisor)
                               : w_rem_y_sh[c_CNT_W-1:0];

    // Clamp the finished quotients into the frame
    assign w_x_clamp = (r_quo_x > c_X_MAX) ? c_H_LAST : r_quo_x[c_HW-1:0];
    assign w_y_clamp = (r_quo_y > c_Y_MAX) ? c_V_LAST : r_quo_y[c_VW-1:0];

    assign busy_out = (r_state != c_ACCUM);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state           <= c_ACCUM;
            r_count           <= '0;
            r_sum_x           <= '0;
            r_sum_y           <= '0;
            r_divisor         <= '0;
            r_quo_x           <= '0;
            r_quo_y           <= '0;
            r_rem_x           <= '0;
            r_rem_y           <= '0;
            r_iter            <= '0;
            x_center          <= '0;
            y_center          <= '0;
            find_corners_flag <= 1'b0;
        end else begin
            find_corners_flag <= 1'b0;

            // The last pixel always closes the frame being accumulated.
            // Outside ACCUM its totals are simply discarded.
            if (w_last) begin
                r_count <= '0;
                r_sum_x <= '0;
                r_sum_y <= '0;
            end else begin
                r_count <= w_count_add;
                r_sum_x <= w_sum_x_add;
                r_sum_y <= w_sum_y_add;
            end

            case (r_state)
                c_ACCUM: begin
                    if (w_last) begin
                        r_divisor <= w_count_add;
                        r_quo_x   <= w_sum_x_add;
                        r_quo_y   <= w_sum_y_add;
                        r_rem_x   <= '0;
                        r_rem_y   <= '0;
                        r_iter    <= '0;
                        if (w_enough) begin
                            r_state <= c_DIVIDE;
                        end
                    end
                end

                c_DIVIDE: begin
                    r_rem_x <= w_rem_x_nx;
                    r_rem_y <= w_rem_y_nx;
                    r_quo_x <= {r_quo_x[c_SUM_W-2:0], w_ge_x};
                    r_quo_y <= {r_quo_y[c_SUM_W-2:0], w_ge_y};
                    r_iter  <= r_iter + 1'b1;
                    if (r_iter == c_LAST_ITER) begin
                        r_state <= c_OUTPUT;
                    end
                end

                c_OUTPUT: begin
                    x_center          <= w_x_clamp;
                    y_center          <= w_y_clamp;
                    find_corners_flag <= 1'b1;
                    r_state           <= c_ACCUM;
                end

                default: begin
                    r_state <= c_ACCUM;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
